// File: rtl/serial_complementer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_complementer_pkg                                      |
// | Description : State encoding, mode constants and carry-seed helper for    |
// |               the bit-serial one's/two's complementer.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package serial_complementer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_TWOS = 1'b0;
    localparam logic MODE_ONES = 1'b1;

    // Two's complement is invert-plus-one, so the serial carry starts at 1.
    function automatic logic init_carry(input logic mode);
        return (mode == MODE_ONES) ? 1'b0 : 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_comp_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_comp_cell                                             |
// | Description : One bit of serial complement: inverted input plus carry.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_comp_cell (
    input  logic b,
    input  logic c,
    output logic res,
    output logic c_next
);

    assign res    = ~b ^ c;
    assign c_next = ~b & c;

endmodule
`default_nettype wire

// File: rtl/serial_complementer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_complementer                                          |
// | Description : Bit-serial one's/two's complementer, LSB first, WIDTH cycles |
// |               per operand with registered result, carry and overflow.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_complementer
    import serial_complementer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] num,
    input  logic             mode,
    output logic [WIDTH-1:0] comp_reg,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic             sout,
    output logic             sout_valid
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_comp_reg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_c;
    logic               r_mode;
    logic               r_carry;
    logic               r_ovf;

    logic               w_bit;
    logic               w_c_next;
    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    serial_comp_cell u_cell (
        .b      (r_shift[0]),
        .c      (r_c),
        .res    (w_bit),
        .c_next (w_c_next)
    );

    // A load is honoured from IDLE or DONE; requests during SHIFT are dropped.
    assign w_start    = load && (r_state != SHIFT);
    assign w_last     = (r_state == SHIFT) && (r_cnt == c_last_cnt);
    assign w_res_next = {w_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = load ? SHIFT : IDLE;
            SHIFT:   w_next_state = w_last ? DONE : SHIFT;
            DONE:    w_next_state = load ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state == SHIFT);
        sout_valid = (r_state == SHIFT);
        done       = (r_state == DONE);
        sout       = (r_state == SHIFT) ? w_bit : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_c        <= 1'b0;
            r_mode     <= MODE_TWOS;
            r_comp_reg <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_start) begin
            r_shift <= num;
            r_mode  <= mode;
            r_cnt   <= '0;
            r_c     <= init_carry(mode);
        end else if (r_state == SHIFT) begin
            r_shift <= r_shift >> 1;
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            r_c     <= w_c_next;
            // Only the most-negative operand negates to itself with a set MSB.
            if (w_last) begin
                r_comp_reg <= w_res_next;
                r_carry    <= w_c_next;
                r_ovf      <= (r_mode == MODE_TWOS) && (w_res_next == c_most_neg);
            end
        end
    end

    assign comp_reg = r_comp_reg;
    assign carry    = r_carry;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_complementer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_complementer                                       |
// | Description : Directed self-checking bench for serial_complementer at      |
// |               WIDTH=4 and WIDTH=8.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_serial_complementer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       load4 = 1'b0;
    logic [3:0] num4  = '0;
    logic       mode4 = 1'b0;
    logic [3:0] comp4;
    logic       carry4, ovf4, busy4, done4, sout4, sv4;

    logic       load8 = 1'b0;
    logic [7:0] num8  = '0;
    logic       mode8 = 1'b0;
    logic [7:0] comp8;
    logic       carry8, ovf8, busy8, done8, sout8, sv8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_complementer #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .load       (load4),
        .num        (num4),
        .mode       (mode4),
        .comp_reg   (comp4),
        .carry      (carry4),
        .ovf        (ovf4),
        .busy       (busy4),
        .done       (done4),
        .sout       (sout4),
        .sout_valid (sv4)
    );

    serial_complementer #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .load       (load8),
        .num        (num8),
        .mode       (mode8),
        .comp_reg   (comp8),
        .carry      (carry8),
        .ovf        (ovf8),
        .busy       (busy8),
        .done       (done8),
        .sout       (sout8),
        .sout_valid (sv8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one WIDTH=4 operation; the serial stream must match the result LSB first.
    task automatic run4(input string tag, input logic [3:0] n, input logic m,
                        input logic [3:0] e_comp, input logic e_carry, input logic e_ovf);
        load4 = 1'b1;
        num4  = n;
        mode4 = m;
        tick();
        load4 = 1'b0;
        num4  = '0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, busy4, 1'b1);
            check({tag, "_sv"}, sv4, 1'b1);
            check({tag, "_sout"}, sout4, e_comp[i]);
            check({tag, "_early_done"}, done4, 1'b0);
            tick();
        end
        check({tag, "_done"}, done4, 1'b1);
        check({tag, "_comp"}, comp4, e_comp);
        check({tag, "_carry"}, carry4, e_carry);
        check({tag, "_ovf"}, ovf4, e_ovf);
        check({tag, "_busy_done"}, busy4, 1'b0);
        tick();
        check({tag, "_done_pulse"}, done4, 1'b0);
        check({tag, "_hold"}, comp4, e_comp);
        check({tag, "_hold_ovf"}, ovf4, e_ovf);
    endtask

    initial begin
        logic [7:0] e8;

        #2 rst = 1'b1;
        #1;
        check("rst_comp", comp4, 4'h0);
        check("rst_carry", carry4, 1'b0);
        check("rst_ovf", ovf4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_sout", sout4, 1'b0);
        check("rst_sv", sv4, 1'b0);
        check("rst_comp8", comp8, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", busy4, 1'b0);

        run4("t0001", 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0);
        run4("t0000", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        run4("t1000", 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b1);
        run4("t0111", 4'b0111, 1'b0, 4'b1001, 1'b0, 1'b0);
        run4("o1010", 4'b1010, 1'b1, 4'b0101, 1'b0, 1'b0);
        run4("o0111", 4'b0111, 1'b1, 4'b1000, 1'b0, 1'b0);
        run4("o0000", 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);

        // Second load during SHIFT must be ignored.
        load4 = 1'b1; num4 = 4'b0011; mode4 = 1'b0;
        tick();
        load4 = 1'b1; num4 = 4'b0111; mode4 = 1'b1;
        tick();
        load4 = 1'b0;
        check("ign_busy", busy4, 1'b1);
        tick();
        tick();
        check("ign_early_done", done4, 1'b0);
        tick();
        check("ign_done", done4, 1'b1);
        check("ign_comp", comp4, 4'b1101);
        check("ign_carry", carry4, 1'b0);
        tick();
        check("ign_idle_busy", busy4, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        load4 = 1'b1; num4 = 4'b0111; mode4 = 1'b0;
        tick();
        load4 = 1'b0;
        tick();
        check("mid_busy", busy4, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_comp", comp4, 4'h0);
        check("arst_carry", carry4, 1'b0);
        check("arst_ovf", ovf4, 1'b0);
        check("arst_done", done4, 1'b0);
        check("arst_busy", busy4, 1'b0);
        check("arst_sout", sout4, 1'b0);
        check("arst_sv", sv4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_no_done", done4, 1'b0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_done", done4, 1'b0);
        run4("post_rst", 4'b0010, 1'b0, 4'b1110, 1'b0, 1'b0);

        // WIDTH=8 back-to-back operations with a load in the DONE cycle.
        e8 = 8'hD4;
        load8 = 1'b1; num8 = 8'h2C; mode8 = 1'b0;
        tick();
        load8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("w8a_sout", sout8, e8[i]);
            check("w8a_early_done", done8, 1'b0);
            tick();
        end
        check("w8a_done", done8, 1'b1);
        check("w8a_comp", comp8, 8'hD4);
        check("w8a_carry", carry8, 1'b0);
        check("w8a_ovf", ovf8, 1'b0);
        load8 = 1'b1; num8 = 8'h01; mode8 = 1'b0;
        tick();
        load8 = 1'b0;
        check("w8b_busy", busy8, 1'b1);
        check("w8b_done_low", done8, 1'b0);
        check("w8b_hold", comp8, 8'hD4);
        for (int i = 0; i < 8; i++) begin
            check("w8b_sout", sout8, 1'b1);
            check("w8b_early_done", done8, 1'b0);
            tick();
        end
        check("w8b_done", done8, 1'b1);
        check("w8b_comp", comp8, 8'hFF);
        check("w8b_carry", carry8, 1'b0);
        check("w8b_ovf", ovf8, 1'b0);
        tick();
        check("w8b_pulse", done8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serial_complementer.md
SERIAL_COMPLEMENTER -- requirements
Module: serial_complementer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port load, input, 1, start request; sampled on rising clk edge.
REQ-005 SHALL have port num, input, WIDTH, operand; captured with load.
REQ-006 SHALL have port mode, input, 1, operation select: 0 = two's complement, 1 = one's complement; captured with load.
REQ-007 SHALL have port comp_reg, output, WIDTH, registered result; updates only on completion.
REQ-008 SHALL have port carry, output, 1, registered final serial carry of the completed operation.
REQ-009 SHALL have port ovf, output, 1, registered overflow flag of the completed operation.
REQ-010 SHALL have port busy, output, 1, high while in SHIFT.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port sout, output, 1, current serial result bit, LSB first.
REQ-013 SHALL have port sout_valid, output, 1, qualifies sout; equals busy.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 In IDLE or DONE, load=1 at edge k SHALL capture num into a shift register, capture mode, set bit counter to 0, set serial carry to 1 (mode 0) or 0 (mode 1), and enter SHIFT.
REQ-016 Each SHIFT edge SHALL process shift-register LSB b with carry c: result bit = ~b ^ c, next c = ~b & c; shift right; result bit enters the MSB of the result shift path; counter increments.
REQ-017 At edge k+WIDTH, the edge processing the last bit, the block SHALL load comp_reg with the full result, load carry with the final c, assert done, and enter DONE.
REQ-018 Latency SHALL be WIDTH cycles from the load edge to the first cycle with done=1; done SHALL be high for exactly one cycle.
REQ-019 DONE SHALL return to IDLE on the next edge unless load=1, which SHALL start a new operation back-to-back per REQ-015.
REQ-020 load while in SHIFT SHALL be ignored; num and mode SHALL then have no effect.
REQ-021 comp_reg, carry and ovf SHALL hold their values between completions.
REQ-022 ovf SHALL be 1 only when mode=0 and the operand was 1 followed by WIDTH-1 zeros (most-negative value); otherwise 0.
REQ-023 carry SHALL be 1 only when mode=0 and the operand was all zeros.
REQ-024 sout SHALL equal ~b ^ c combinationally in SHIFT and 0 otherwise.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, comp_reg 0, carry 0, ovf 0, done 0, busy 0, sout 0, sout_valid 0, counter 0, internal carry 0, regardless of clk.
REQ-026 Reset mid-SHIFT SHALL abort the operation with no done pulse; the first load after rst deasserts SHALL operate normally.

Structure
REQ-027 Package serial_complementer_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and mode encoding constants (MODE_TWOS=0, MODE_ONES=1).
REQ-028 The per-bit logic of REQ-016 SHALL be a sub-module serial_comp_cell: inputs b and c, outputs result bit and next carry, purely combinational.
REQ-029 Counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-030 WIDTH=4, mode=0, num=0001, load one cycle -> done after 4 edges; comp_reg=1111, carry=0, ovf=0; sout sequence 1,1,1,1.
REQ-031 WIDTH=4, mode=0, num=0000 -> comp_reg=0000, carry=1, ovf=0; num=1000 -> comp_reg=1000, ovf=1, carry=0.
REQ-032 WIDTH=4, mode=1, num=1010 -> comp_reg=0101, carry=0, ovf=0.
REQ-033 WIDTH=4: load num=0011, then load num=0111 during SHIFT -> second load ignored, comp_reg=1101; rst pulse mid-SHIFT -> all outputs 0, no done; next load num=0010 -> comp_reg=1110.
REQ-034 WIDTH=8, mode=0, num=0x2C, then load num=0x01 in the DONE cycle -> comp_reg=0xD4 with done, then comp_reg=0xFF with done exactly 8 cycles later; no IDLE cycle in between.
